// File: rtl/dual_port_router_scheduler_if.sv
// Handshake bundle for dual_port_router_scheduler: register bus,
// requester ingress beats and the single router egress port.
interface dual_port_router_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  logic [3:0]            reg_addr;
  logic [31:0]           reg_wdata;
  logic                  reg_en;
  logic                  reg_we;
  logic [31:0]           reg_rdata;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ*2-1:0]  req_addr;
  logic [NUM_REQ-1:0]    req_ready;
  logic [DATA_W-1:0]     out_data;
  logic [1:0]            out_addr;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output reg_addr, reg_wdata, reg_en, reg_we,
    output req_valid, req_data, req_addr,
    output out_ready,
    input  reg_rdata, req_ready,
    input  out_data, out_addr, out_valid
  );

  modport slave (
    input  reg_addr, reg_wdata, reg_en, reg_we,
    input  req_valid, req_data, req_addr,
    input  out_ready,
    output reg_rdata, req_ready,
    output out_data, out_addr, out_valid
  );
endinterface

// File: rtl/dual_port_router_scheduler.sv
// Weighted round-robin scheduler: 4 requesters share one router port.
// Ports: clk, rst_n (async low), bus (slave: regs, req_*, out_*).
module dual_port_router_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
) (
  input logic clk,
  input logic rst_n,
  dual_port_router_scheduler_if.slave bus
);

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  state_t state_q, state_d;

  logic        en_q;
  logic [15:0] wgt_q;
  logic [31:0] cnt_q;
  logic [1:0]  rr_q, rr_d;
  logic [1:0]  g_q, g_d;
  logic [3:0]  cred_q, cred_d;

  logic        wr;
  logic        sel_ctrl;
  logic        sel_wgt;
  logic        sel_stat;
  logic        sel_cnt;
  logic [31:0] rdata;

  logic [1:0]  pick;
  logic [1:0]  idx;
  logic        found;
  logic [3:0]  pick_w;
  logic [3:0]  load;

  logic              g_valid;
  logic [DATA_W-1:0] g_data;
  logic [1:0]        g_addr;
  logic              busy;
  logic              xfer;

  logic               ov;
  logic [DATA_W-1:0]  od;
  logic [1:0]         oa;
  logic [NUM_REQ-1:0] rdy;

  logic unused_wdata;
  assign unused_wdata = ^bus.reg_wdata[31:16];

  assign wr       = bus.reg_en && bus.reg_we;
  assign sel_ctrl = bus.reg_addr == 4'h0;
  assign sel_wgt  = bus.reg_addr == 4'h4;
  assign sel_stat = bus.reg_addr == 4'h8;
  assign sel_cnt  = bus.reg_addr == 4'hC;

  assign busy = state_q == BURST;

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      sel_ctrl: rdata = {31'd0, en_q};
      sel_wgt:  rdata = {16'd0, wgt_q};
      sel_stat: rdata = {26'd0, rr_q, 1'b0,
                         busy ? g_q : 2'd0, busy};
      sel_cnt:  rdata = cnt_q;
      default:  rdata = '0;
    endcase
  end

  assign bus.reg_rdata = rdata;

  // First valid requester starting at rr_q, wrapping mod 4.
  always_comb begin
    pick  = rr_q;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < 4; k++) begin
      idx = rr_q + 2'(k);
      if (!found && bus.req_valid[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  assign pick_w = wgt_q[{pick, 2'b00} +: 4];
  // A zero weight still grants one beat.
  assign load   = (pick_w == 4'd0) ? 4'd1 : pick_w;

  assign g_valid = bus.req_valid[g_q];
  assign g_data  = bus.req_data[int'(g_q)*DATA_W +: DATA_W];
  assign g_addr  = bus.req_addr[{g_q, 1'b0} +: 2];
  assign xfer    = busy && g_valid && bus.out_ready;

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    cred_d  = cred_q;
    rr_d    = rr_q;
    ov      = 1'b0;
    od      = '0;
    oa      = '0;
    rdy     = '0;
    unique case (state_q)
      IDLE: begin
        if (en_q && found) begin
          g_d     = pick;
          cred_d  = load;
          state_d = BURST;
        end
      end
      BURST: begin
        ov       = g_valid;
        od       = g_data;
        oa       = g_addr;
        rdy[g_q] = bus.out_ready;
        if (xfer) begin
          cred_d = cred_q - 4'd1;
        end
        // Exit on last credited beat or when the owner drops valid.
        if ((xfer && cred_q == 4'd1) || !g_valid) begin
          state_d = IDLE;
          rr_d    = g_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.out_valid = ov;
  assign bus.out_data  = od;
  assign bus.out_addr  = oa;
  assign bus.req_ready = rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      g_q     <= '0;
      rr_q    <= '0;
      cred_q  <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      rr_q    <= rr_d;
      cred_q  <= cred_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q  <= 1'b1;
      wgt_q <= 16'h1111;
      cnt_q <= '0;
    end else begin
      if (wr && sel_ctrl) begin
        en_q <= bus.reg_wdata[0];
      end
      if (wr && sel_wgt) begin
        wgt_q <= bus.reg_wdata[15:0];
      end
      if (xfer) begin
        cnt_q <= cnt_q + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_dual_port_router_scheduler.sv
// Directed table-driven bench for dual_port_router_scheduler.
// Rows are consecutive clock cycles; corner cases are hand sequences.
module tb_dual_port_router_scheduler;

  localparam logic [7:0] A0 = 8'hA0;
  localparam logic [7:0] A1 = 8'hA1;
  localparam logic [7:0] A2 = 8'hA2;
  localparam logic [7:0] A3 = 8'hA3;

  typedef struct {
    logic [3:0]  rv;
    logic        ordy;
    logic [3:0]  addr;
    logic [3:0]  rdy;
    logic        ov;
    logic [7:0]  data;
    logic [31:0] rd;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  vec_t tv[27];

  dual_port_router_scheduler_if #(
    .NUM_REQ(4),
    .DATA_W (8)
  ) bus ();

  dual_port_router_scheduler #(
    .NUM_REQ(4),
    .DATA_W (8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(
    logic [3:0] rv, logic ordy, logic [3:0] addr,
    logic [3:0] rdy, logic ov, logic [7:0] data,
    logic [31:0] rd
  );
    vec_t v;
    v.rv   = rv;
    v.ordy = ordy;
    v.addr = addr;
    v.rdy  = rdy;
    v.ov   = ov;
    v.data = data;
    v.rd   = rd;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(logic [3:0] a, logic [31:0] e,
                    string nm);
    bus.reg_addr = a;
    #1;
    chk(nm, bus.reg_rdata, e);
  endtask

  task automatic wr(logic [3:0] a, logic [31:0] d);
    cyc();
    bus.reg_en    = 1'b1;
    bus.reg_we    = 1'b1;
    bus.reg_addr  = a;
    bus.reg_wdata = d;
    cyc();
    bus.reg_en = 1'b0;
    bus.reg_we = 1'b0;
  endtask

  task automatic out_chk(string nm, logic ov,
                         logic [7:0] d, logic [3:0] r);
    chk({nm, "_ov"}, 32'(bus.out_valid), 32'(ov));
    chk({nm, "_data"}, 32'(bus.out_data), 32'(d));
    chk({nm, "_rdy"}, 32'(bus.req_ready), 32'(r));
  endtask

  task automatic pulse_rst();
    cyc();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
  endtask

  task automatic run_rows(int lo, int hi);
    logic [1:0] ea;
    for (int i = lo; i <= hi; i++) begin
      cyc();
      bus.req_valid = tv[i].rv;
      bus.out_ready = tv[i].ordy;
      bus.reg_addr  = tv[i].addr;
      #1;
      ea = tv[i].ov ? 2'd3 - tv[i].data[1:0] : 2'd0;
      chk($sformatf("row%0d_ov", i),
          32'(bus.out_valid), 32'(tv[i].ov));
      chk($sformatf("row%0d_data", i),
          32'(bus.out_data), 32'(tv[i].data));
      chk($sformatf("row%0d_oaddr", i),
          32'(bus.out_addr), 32'(ea));
      chk($sformatf("row%0d_rdy", i),
          32'(bus.req_ready), 32'(tv[i].rdy));
      chk($sformatf("row%0d_rdata", i),
          bus.reg_rdata, tv[i].rd);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // Round robin, all weights 1, STATUS tracked.
    tv[0]  = mk(4'hF, 1, 4'h8, 4'h0, 0, 8'h0, 32'h00);
    tv[1]  = mk(4'hF, 1, 4'h8, 4'h1, 1, A0,   32'h01);
    tv[2]  = mk(4'hF, 1, 4'h8, 4'h0, 0, 8'h0, 32'h10);
    tv[3]  = mk(4'hF, 1, 4'h8, 4'h2, 1, A1,   32'h13);
    tv[4]  = mk(4'hF, 1, 4'h8, 4'h0, 0, 8'h0, 32'h20);
    tv[5]  = mk(4'hF, 1, 4'h8, 4'h4, 1, A2,   32'h25);
    tv[6]  = mk(4'hF, 1, 4'h8, 4'h0, 0, 8'h0, 32'h30);
    tv[7]  = mk(4'hF, 1, 4'h8, 4'h8, 1, A3,   32'h37);
    tv[8]  = mk(4'hF, 1, 4'hC, 4'h0, 0, 8'h0, 32'h04);
    tv[9]  = mk(4'hF, 1, 4'h8, 4'h1, 1, A0,   32'h01);
    tv[10] = mk(4'h0, 1, 4'h8, 4'h0, 0, 8'h0, 32'h10);
    // Weights 0x0003, req0/req1, then a 5-cycle stall.
    tv[11] = mk(4'h3, 1, 4'hC, 4'h0, 0, 8'h0, 32'd0);
    tv[12] = mk(4'h3, 1, 4'hC, 4'h1, 1, A0,   32'd0);
    tv[13] = mk(4'h3, 1, 4'hC, 4'h1, 1, A0,   32'd1);
    tv[14] = mk(4'h3, 1, 4'hC, 4'h1, 1, A0,   32'd2);
    tv[15] = mk(4'h3, 1, 4'hC, 4'h0, 0, 8'h0, 32'd3);
    tv[16] = mk(4'h3, 1, 4'hC, 4'h2, 1, A1,   32'd3);
    tv[17] = mk(4'h3, 1, 4'hC, 4'h0, 0, 8'h0, 32'd4);
    tv[18] = mk(4'h3, 1, 4'hC, 4'h1, 1, A0,   32'd4);
    for (int i = 19; i <= 23; i++)
      tv[i] = mk(4'h3, 0, 4'hC, 4'h0, 1, A0, 32'd5);
    tv[24] = mk(4'h3, 1, 4'hC, 4'h1, 1, A0,   32'd5);
    tv[25] = mk(4'h3, 1, 4'hC, 4'h1, 1, A0,   32'd6);
    tv[26] = mk(4'h0, 1, 4'hC, 4'h0, 0, 8'h0, 32'd7);

    rst_n         = 1'b0;
    bus.reg_addr  = '0;
    bus.reg_wdata = '0;
    bus.reg_en    = 1'b0;
    bus.reg_we    = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = {A3, A2, A1, A0};
    bus.req_addr  = 8'h1B;
    bus.out_ready = 1'b0;

    #12;
    out_chk("reset", 1'b0, 8'h0, 4'h0);
    chk("reset_oaddr", 32'(bus.out_addr), 32'd0);
    rst_n = 1'b1;
    rd(4'h0, 32'h1, "reset_ctrl");
    rd(4'h4, 32'h1111, "reset_wgt");
    rd(4'h8, 32'h0, "reset_status");
    rd(4'hC, 32'h0, "reset_cnt");
    rd(4'h2, 32'h0, "unmapped_rd");

    run_rows(0, 10);

    pulse_rst();
    wr(4'h4, 32'h0000_0003);
    rd(4'h4, 32'h3, "wgt_rd");
    run_rows(11, 26);

    // Enable cleared: nothing granted.
    wr(4'h0, 32'h0);
    wr(4'h8, 32'hFFFF_FFFF);
    rd(4'h8, 32'h10, "ro_status_wr");
    bus.req_valid = 4'hF;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      out_chk($sformatf("dis%0d", i), 1'b0, 8'h0, 4'h0);
    end
    rd(4'h0, 32'h0, "ctrl_off");

    // Enable cleared mid-burst: burst completes.
    bus.req_valid = 4'h0;
    wr(4'h4, 32'h0000_0333);
    wr(4'h0, 32'h1);
    bus.req_valid = 4'h2;
    #1;
    out_chk("mb_idle", 1'b0, 8'h0, 4'h0);
    cyc();
    out_chk("mb_b1", 1'b1, A1, 4'h2);
    bus.reg_en    = 1'b1;
    bus.reg_we    = 1'b1;
    bus.reg_addr  = 4'h0;
    bus.reg_wdata = 32'h0;
    cyc();
    bus.reg_en = 1'b0;
    bus.reg_we = 1'b0;
    #1;
    out_chk("mb_b2", 1'b1, A1, 4'h2);
    cyc();
    out_chk("mb_b3", 1'b1, A1, 4'h2);
    for (int i = 0; i < 3; i++) begin
      cyc();
      out_chk($sformatf("mb_post%0d", i),
              1'b0, 8'h0, 4'h0);
    end
    rd(4'hC, 32'd10, "mb_cnt");

    // Reset mid-burst on requester 2.
    bus.req_valid = 4'h0;
    wr(4'h0, 32'h1);
    bus.req_valid = 4'h4;
    #1;
    out_chk("rb_idle", 1'b0, 8'h0, 4'h0);
    cyc();
    out_chk("rb_g2", 1'b1, A2, 4'h4);
    rd(4'h8, 32'h25, "rb_status");
    rst_n = 1'b0;
    #1;
    out_chk("rb_in_rst", 1'b0, 8'h0, 4'h0);
    chk("rb_oaddr", 32'(bus.out_addr), 32'd0);
    rd(4'h8, 32'h0, "rb_status_rst");
    rd(4'hC, 32'h0, "rb_cnt_rst");
    rst_n = 1'b1;
    bus.req_valid = 4'h5;
    rd(4'h4, 32'h1111, "rb_wgt");
    cyc();
    out_chk("rb_first", 1'b1, A0, 4'h1);
    bus.req_valid = 4'h0;
    cyc();
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
